video_timing: RTL and testbench
===============================

VIDEO_TIMING -- requirements
Module: video_timing

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, meaning active pixels per line.
REQ-002 SHALL have parameters H_FP, H_SYNC and H_BP, defaults 16/96/48, meaning horizontal front porch, sync and back porch in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480, meaning active lines per frame.
REQ-004 SHALL have parameters V_FP, V_SYNC and V_BP, defaults 10/2/33, meaning vertical front porch, sync and back porch in lines.
REQ-005 SHALL have parameters H_POL and V_POL, default 0, meaning sync active level (1 = active-high).
REQ-006 SHALL have parameter CORDW, default 10, meaning coordinate width.
REQ-007 SHALL have parameter FRAMEW, default 16, meaning frame counter width.
REQ-008 SHALL have port clk_pix, input, 1 bit: pixel clock, the only clock.
REQ-009 SHALL have port rst_n_pix, input, 1 bit: reset, asynchronous assert, active-low.
REQ-010 SHALL have port en, input, 1 bit: advance one pixel per cycle when high.
REQ-011 SHALL have ports sx and sy, output, CORDW bits each: current pixel column and line.
REQ-012 SHALL have ports hsync, vsync and de, output, 1 bit each: syncs and data enable.
REQ-013 SHALL have ports line, frame and vblank, output, 1 bit each: one-cycle strobes.
REQ-014 SHALL have port frame_cnt, output, FRAMEW bits: completed-frame count.

Function
REQ-015 SHALL define H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise; elaboration SHALL fail if 2**CORDW < max(H_TOTAL,V_TOTAL), or if any of H_BP, V_BP, H_SYNC or V_SYNC is 0.
REQ-016 SHALL, on each clk_pix edge with en=1: sx increments; at sx=H_TOTAL-1, sx wraps to 0 and sy increments; at sy=V_TOTAL-1, sy wraps to 0.
REQ-017 SHALL hold sx, sy, hsync, vsync, de and frame_cnt when en=0, and force line, frame and vblank to 0.
REQ-018 SHALL register all outputs, each aligned to the sx/sy value presented in the same cycle (zero skew, no combinational outputs).
REQ-019 SHALL drive de=1 iff sx<H_ACTIVE and sy<V_ACTIVE.
REQ-020 SHALL drive hsync=H_POL iff H_ACTIVE+H_FP <= sx < H_ACTIVE+H_FP+H_SYNC, and ~H_POL otherwise.
REQ-021 SHALL apply the REQ-020 rule to vsync using sy, the V_* parameters and V_POL; vsync SHALL change only where sx=0.
REQ-022 SHALL assert line for one cycle with sx=0, frame for one cycle with sx=0 and sy=0, and vblank for one cycle with sx=0 and sy=V_ACTIVE.
REQ-023 SHALL increment frame_cnt in the same cycle frame asserts, wrapping from all-ones to 0 silently.
REQ-024 SHALL treat en toggling mid-line as a pure stall: the output sequence with stalls removed equals the unstalled sequence.

Reset
REQ-025 SHALL, while rst_n_pix=0, immediately force sx=H_TOTAL-1, sy=V_TOTAL-1, de=0, hsync=~H_POL, vsync=~V_POL, line=0, frame=0, vblank=0 and frame_cnt=0.
REQ-026 SHALL, on the first en=1 edge after reset release, present sx=0, sy=0, de=1, line=1, frame=1 and frame_cnt=1.
REQ-027 SHALL, on reset assertion mid-frame, return to the REQ-025 state without completing the frame and without emitting further strobes.

Verification (H 4/1/1/2 => H_TOTAL 8; V 3/1/1/1 => V_TOTAL 6; pol 1; CORDW 4; FRAMEW 4)
REQ-028 SHALL check: release reset, en=1 -> cycle 1 (sx,sy)=(0,0) with frame=line=de=1; hsync=1 only at sx=5; de=0 for sx 4..7.
REQ-029 SHALL check: run 48 cycles -> vsync=1 exactly for sy=4 (8 cycles); vblank pulses once at (0,3); frame re-asserts at cycle 49 with frame_cnt=2.
REQ-030 SHALL check: hold en=0 for 5 cycles at (2,1) -> outputs frozen, no strobes; resume -> next (3,1).
REQ-031 SHALL check: run 16 frames -> frame_cnt wraps 15->0 at the 16th frame strobe.
REQ-032 SHALL check: assert rst_n_pix low mid-cycle at (6,4) -> outputs reach the REQ-025 state asynchronously (sx=7, sy=5, vsync=0) before the next edge.
REQ-033 SHALL check: default parameters -> 800x525 totals, hsync low for sx 656..751, vsync low for sy 490..491.

Source files
------------

// File: rtl/video_timing.sv
`timescale 1ns / 1ps
// Raster timing generator: pixel/line counters with registered syncs, data enable and strobes.
// Every output is computed from the next counter value, so all outputs line up with sx/sy.
module video_timing #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned CORDW    = 10,
  parameter int unsigned FRAMEW   = 16
) (
  input  logic              clk_pix,
  input  logic              rst_n_pix,
  input  logic              en,
  output logic [CORDW-1:0]  sx,
  output logic [CORDW-1:0]  sy,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              line,
  output logic              frame,
  output logic              vblank,
  output logic [FRAMEW-1:0] frame_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam longint unsigned CoordSpan = 64'd1 << CORDW;

  if ((CoordSpan < 64'(H_TOTAL)) || (CoordSpan < 64'(V_TOTAL)) ||
      (H_BP == 0) || (V_BP == 0) || (H_SYNC == 0) || (V_SYNC == 0)) begin : g_param_check
    $error("video_timing: invalid timing parameters");
  end

  localparam logic [CORDW-1:0] One      = CORDW'(1);
  localparam logic [CORDW-1:0] HLast    = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] HActive  = CORDW'(H_ACTIVE);
  localparam logic [CORDW-1:0] HSyncBeg = CORDW'(H_ACTIVE + H_FP);
  localparam logic [CORDW-1:0] HSyncEnd = CORDW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CORDW-1:0] VLast    = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] VActive  = CORDW'(V_ACTIVE);
  localparam logic [CORDW-1:0] VSyncBeg = CORDW'(V_ACTIVE + V_FP);
  localparam logic [CORDW-1:0] VSyncEnd = CORDW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CORDW-1:0] sx_d, sy_d;
  logic             hsync_d, vsync_d, de_d, line_d, frame_d, vblank_d;

  always_comb begin
    sx_d = sx + One;
    sy_d = sy;
    if (sx == HLast) begin
      sx_d = '0;
      sy_d = (sy == VLast) ? '0 : sy + One;
    end
  end

  // sy only moves on the sx wrap, so vsync naturally changes only where sx is 0.
  always_comb begin
    de_d     = (sx_d < HActive) && (sy_d < VActive);
    hsync_d  = ((sx_d >= HSyncBeg) && (sx_d < HSyncEnd)) ? H_POL : ~H_POL;
    vsync_d  = ((sy_d >= VSyncBeg) && (sy_d < VSyncEnd)) ? V_POL : ~V_POL;
    line_d   = (sx_d == '0);
    frame_d  = (sx_d == '0) && (sy_d == '0);
    vblank_d = (sx_d == '0) && (sy_d == VActive);
  end

  always_ff @(posedge clk_pix or negedge rst_n_pix) begin
    if (!rst_n_pix) begin
      sx        <= HLast;
      sy        <= VLast;
      de        <= 1'b0;
      hsync     <= ~H_POL;
      vsync     <= ~V_POL;
      line      <= 1'b0;
      frame     <= 1'b0;
      vblank    <= 1'b0;
      frame_cnt <= '0;
    end else if (en) begin
      sx     <= sx_d;
      sy     <= sy_d;
      de     <= de_d;
      hsync  <= hsync_d;
      vsync  <= vsync_d;
      line   <= line_d;
      frame  <= frame_d;
      vblank <= vblank_d;
      if (frame_d) begin
        frame_cnt <= frame_cnt + FRAMEW'(1);
      end
    end else begin
      line   <= 1'b0;
      frame  <= 1'b0;
      vblank <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_timing.sv
`timescale 1ns / 1ps
// Bench for video_timing: a small 8x6 raster plus default-timing instances, all checked
// every cycle against an arithmetic model indexed by the number of enabled edges since reset.
module tb_video_timing;

  typedef struct {
    logic [31:0] sx, sy, fc;
    logic        hs, vs, de, ln, fr, vb;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0, en = 1'b0;
  logic rst2_n = 1'b0, en2 = 1'b0;
  int   checks = 0, failures = 0;
  int unsigned k = 0, k2 = 0;

  always #5 clk = ~clk;

  // Small raster: H 4/1/1/2 (8), V 3/1/1/1 (6), active-high syncs.
  logic [3:0] sx, sy, frame_cnt;
  logic       hsync, vsync, de, line, frame, vblank;
  video_timing #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(2),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .CORDW(4), .FRAMEW(4)
  ) u_dut (
    .clk_pix(clk), .rst_n_pix(rst_n), .en(en), .sx(sx), .sy(sy), .hsync(hsync),
    .vsync(vsync), .de(de), .line(line), .frame(frame), .vblank(vblank), .frame_cnt(frame_cnt)
  );

  // Fully default timing.
  logic [9:0]  b_sx, b_sy;
  logic [15:0] b_fc;
  logic        b_hs, b_vs, b_de, b_ln, b_fr, b_vb;
  video_timing u_big (
    .clk_pix(clk), .rst_n_pix(rst2_n), .en(en2), .sx(b_sx), .sy(b_sy), .hsync(b_hs),
    .vsync(b_vs), .de(b_de), .line(b_ln), .frame(b_fr), .vblank(b_vb), .frame_cnt(b_fc)
  );

  // Default vertical timing with a short line so a whole 525-line frame fits quickly.
  logic [9:0]  m_sx, m_sy;
  logic [15:0] m_fc;
  logic        m_hs, m_vs, m_de, m_ln, m_fr, m_vb;
  video_timing #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(2)) u_mid (
    .clk_pix(clk), .rst_n_pix(rst2_n), .en(en2), .sx(m_sx), .sy(m_sy), .hsync(m_hs),
    .vsync(m_vs), .de(m_de), .line(m_ln), .frame(m_fr), .vblank(m_vb), .frame_cnt(m_fc)
  );

  wire [17:0] obs_s = {sx, sy, hsync, vsync, de, line, frame, vblank, frame_cnt};
  wire [41:0] obs_b = {b_sx, b_sy, b_hs, b_vs, b_de, b_ln, b_fr, b_vb, b_fc};
  wire [41:0] obs_m = {m_sx, m_sy, m_hs, m_vs, m_de, m_ln, m_fr, m_vb, m_fc};

  // k = enabled edges since reset release; pixel n = k-1 within an endless raster scan.
  function automatic exp_t model(input int unsigned kk, input int unsigned ha, hf, hw, hb,
                                 input int unsigned va, vf, vw, vb, input bit pol,
                                 input int unsigned fw);
    exp_t e;
    int unsigned ht, vt, n, x, y;
    ht = ha + hf + hw + hb;
    vt = va + vf + vw + vb;
    if (kk == 0) begin
      e.sx = ht - 1; e.sy = vt - 1; e.fc = 0;
      e.hs = ~pol; e.vs = ~pol; e.de = 1'b0;
      e.ln = 1'b0; e.fr = 1'b0; e.vb = 1'b0;
    end else begin
      n = (kk - 1) % (ht * vt);
      x = n % ht;
      y = n / ht;
      e.sx = x; e.sy = y;
      e.de = (x < ha) && (y < va);
      e.hs = (x >= ha + hf && x < ha + hf + hw) ? pol : ~pol;
      e.vs = (y >= va + vf && y < va + vf + vw) ? pol : ~pol;
      e.ln = (x == 0);
      e.fr = (n == 0);
      e.vb = (x == 0) && (y == va);
      e.fc = ((kk - 1) / (ht * vt) + 1) % (32'd1 << fw);
    end
    return e;
  endfunction

  function automatic logic [17:0] exp_small(input int unsigned kk, input bit stalled);
    exp_t e;
    e = model(kk, 4, 1, 1, 2, 3, 1, 1, 1, 1'b1, 4);
    if (stalled) begin
      e.ln = 1'b0; e.fr = 1'b0; e.vb = 1'b0;
    end
    return {e.sx[3:0], e.sy[3:0], e.hs, e.vs, e.de, e.ln, e.fr, e.vb, e.fc[3:0]};
  endfunction

  function automatic logic [41:0] exp_wide(input int unsigned kk, input bit short_line);
    exp_t e;
    if (short_line) e = model(kk, 4, 1, 1, 2, 480, 10, 2, 33, 1'b0, 16);
    else            e = model(kk, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 16);
    return {e.sx[9:0], e.sy[9:0], e.hs, e.vs, e.de, e.ln, e.fr, e.vb, e.fc[15:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1;
    step(); step();
    checks++;
    if (obs_s !== exp_small(0, 1'b0)) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", obs_s, exp_small(0, 1'b0));
    end
    en = 1'b0;
    rst_n = 1'b1;
    k = 0;
    step();
    checks++;
    if (obs_s !== exp_small(0, 1'b0)) begin
      failures++;
      $display("FAIL idle_after_release got=%h exp=%h", obs_s, exp_small(0, 1'b0));
    end
  endtask

  task automatic test_first_frame();
    int vs_cnt = 0, vb_cnt = 0;
    en = 1'b1;
    for (int i = 0; i < 48; i++) begin
      step(); k++;
      checks++;
      if (obs_s !== exp_small(k, 1'b0)) begin
        failures++;
        $display("FAIL first_frame k=%0d got=%h exp=%h", k, obs_s, exp_small(k, 1'b0));
      end
      if (vsync === 1'b1 && sy === 4'd4) vs_cnt++;
      if (vblank === 1'b1 && sx === 4'd0 && sy === 4'd3) vb_cnt++;
    end
    checks++;
    if (vs_cnt != 8) begin
      failures++;
      $display("FAIL vsync_len got=%0d exp=8", vs_cnt);
    end
    checks++;
    if (vb_cnt != 1) begin
      failures++;
      $display("FAIL vblank_count got=%0d exp=1", vb_cnt);
    end
    step(); k++;
    checks++;
    if ({frame, frame_cnt} !== 5'b1_0010) begin
      failures++;
      $display("FAIL frame2 got frame=%b cnt=%0d exp frame=1 cnt=2", frame, frame_cnt);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 48 && ((k - 1) % 48) != 10; i++) begin
      step(); k++;
    end
    checks++;
    if ({sx, sy} !== {4'd2, 4'd1}) begin
      failures++;
      $display("FAIL stall_pos got=(%0d,%0d) exp=(2,1)", sx, sy);
    end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (obs_s !== exp_small(k, 1'b1)) begin
        failures++;
        $display("FAIL stall_hold i=%0d got=%h exp=%h", i, obs_s, exp_small(k, 1'b1));
      end
    end
    en = 1'b1;
    step(); k++;
    checks++;
    if (obs_s !== exp_small(k, 1'b0) || {sx, sy} !== {4'd3, 4'd1}) begin
      failures++;
      $display("FAIL stall_resume got=%h exp=%h", obs_s, exp_small(k, 1'b0));
    end
    for (int i = 0; i < 200; i++) begin
      en = 1'($urandom_range(0, 1));
      step();
      if (en) k++;
      checks++;
      if (obs_s !== exp_small(k, !en)) begin
        failures++;
        $display("FAIL random_stall k=%0d got=%h exp=%h", k, obs_s, exp_small(k, !en));
      end
    end
    en = 1'b1;
  endtask

  task automatic test_frame_wrap();
    bit seen_wrap = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 800; i++) begin
      step(); k++;
      checks++;
      if (obs_s !== exp_small(k, 1'b0)) begin
        failures++;
        $display("FAIL frame_run k=%0d got=%h exp=%h", k, obs_s, exp_small(k, 1'b0));
      end
      if (frame === 1'b1 && frame_cnt === 4'd0) seen_wrap = 1'b1;
    end
    checks++;
    if (seen_wrap !== 1'b1) begin
      failures++;
      $display("FAIL frame_cnt_wrap got=%b exp=1", seen_wrap);
    end
  endtask

  task automatic test_async_reset();
    en = 1'b1;
    for (int i = 0; i < 48 && ((k - 1) % 48) != 38; i++) begin
      step(); k++;
    end
    checks++;
    if ({sx, sy, vsync} !== {4'd6, 4'd4, 1'b1}) begin
      failures++;
      $display("FAIL pre_reset_pos got=(%0d,%0d,%b) exp=(6,4,1)", sx, sy, vsync);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs_s !== exp_small(0, 1'b0)) begin
      failures++;
      $display("FAIL async_reset got=%h exp=%h", obs_s, exp_small(0, 1'b0));
    end
    step(); step();
    checks++;
    if (obs_s !== exp_small(0, 1'b0)) begin
      failures++;
      $display("FAIL reset_held got=%h exp=%h", obs_s, exp_small(0, 1'b0));
    end
    rst_n = 1'b1;
    k = 0;
    en = 1'b1;
    step(); k++;
    checks++;
    if (obs_s !== exp_small(1, 1'b0) || {frame, line, de, frame_cnt} !== 7'b111_0001) begin
      failures++;
      $display("FAIL first_after_reset got=%h exp=%h", obs_s, exp_small(1, 1'b0));
    end
    for (int i = 0; i < 100; i++) begin
      en = 1'($urandom_range(0, 3) != 0);
      step();
      if (en) k++;
      checks++;
      if (obs_s !== exp_small(k, !en)) begin
        failures++;
        $display("FAIL post_reset k=%0d got=%h exp=%h", k, obs_s, exp_small(k, !en));
      end
    end
  endtask

  task automatic test_defaults();
    rst2_n = 1'b0; en2 = 1'b0;
    step();
    checks++;
    if (obs_b !== exp_wide(0, 1'b0)) begin
      failures++;
      $display("FAIL default_reset got=%h exp=%h", obs_b, exp_wide(0, 1'b0));
    end
    rst2_n = 1'b1;
    k2 = 0;
    en2 = 1'b1;
    for (int i = 0; i < 4300; i++) begin
      step(); k2++;
      checks++;
      if (obs_b !== exp_wide(k2, 1'b0)) begin
        failures++;
        $display("FAIL default_h k=%0d got=%h exp=%h", k2, obs_b, exp_wide(k2, 1'b0));
      end
      checks++;
      if (obs_m !== exp_wide(k2, 1'b1)) begin
        failures++;
        $display("FAIL default_v k=%0d got=%h exp=%h", k2, obs_m, exp_wide(k2, 1'b1));
      end
    end
    en2 = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_frame();
    test_stall();
    test_frame_wrap();
    test_async_reset();
    test_defaults();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
